// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage sitting directly upstream of the decode stage. It owns
// the fetch PC, issues word reads on the instruction bus, and buffers returned
// instructions in a small in-order fetch queue (FQ). The FQ head is presented
// to decode as {valid, pc, inst, exception}. Redirects from execute/commit
// (branch, jump, trap, mret) flush wrong-path work; responses that were already
// in flight at the time of a redirect are counted and silently dropped.
//
// Parameters
//   XLEN      datapath / PC width
//   RESET_PC  first PC fetched after reset
//   FQ_DEPTH  fetch-queue entries; also caps the number of in-flight requests
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst_n            synchronous reset, active low
//   redirect_valid   redirect fetch to redirect_pc this cycle (highest priority)
//   redirect_pc      new fetch PC
//   id_ready         decode accepts the head entry (low = stall)
//   ibus_req         instruction bus read request
//   ibus_addr        request address (word aligned whenever ibus_req is high)
//   ibus_gnt         request accepted this cycle
//   ibus_rvalid      read data valid, in order, at least one cycle after gnt
//   ibus_rdata       returned instruction word
//   ibus_err         access fault on this response
//   id_valid         FQ head valid
//   id_pc            PC of the head entry
//   id_inst          head instruction zero-extended to XLEN, 0 for exceptions
//   if2id_exp_flag   head entry carries a fetch exception
//   if2id_exp_cause  0 = instruction address misaligned, 1 = access fault
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int              FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            ibus_req,
  output logic [XLEN-1:0] ibus_addr,
  input  logic            ibus_gnt,
  input  logic            ibus_rvalid,
  input  logic [31:0]     ibus_rdata,
  input  logic            ibus_err,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic            if2id_exp_flag,
  output logic            if2id_exp_cause
);

  // Counter width holds 0..FQ_DEPTH; the credit sum needs one extra bit.
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

  // Fetch PC and control state
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            halt;

  // In-flight PC queue: PCs of granted requests whose responses are still due
  logic [XLEN-1:0] inf_pc [FQ_DEPTH];
  logic [PW-1:0]   inf_wr;
  logic [PW-1:0]   inf_rd;

  // Fetch queue storage
  logic [XLEN-1:0] fq_pc    [FQ_DEPTH];
  logic [31:0]     fq_inst  [FQ_DEPTH];
  logic            fq_exp   [FQ_DEPTH];
  logic            fq_cause [FQ_DEPTH];
  logic [PW-1:0]   fq_wr;
  logic [PW-1:0]   fq_rd;
  logic [CW-1:0]   fq_count;

  // Datapath / handshake decode
  logic            aligned;
  logic            credit_ok;
  logic            issue;
  logic            resp_live;
  logic            resp_take;
  logic            misalign_push;
  logic            fq_push;
  logic            fq_pop;
  logic            set_halt;
  logic [XLEN-1:0] push_pc;
  logic [31:0]     push_inst;
  logic            push_exp;
  logic            push_cause;

  // Circular pointer increment that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign aligned = (pc_q[1:0] == 2'b00);

  // Every granted request reserves an FQ slot until its entry is consumed, so
  // the queue can never overflow. Counts are registered, so a pop this cycle
  // only frees credit from the next cycle on.
  assign credit_ok = (SW'(outstanding) + SW'(fq_count)) < SW'(FQ_DEPTH);

  assign ibus_req  = rst_n & ~redirect_valid & ~halt & aligned & credit_ok;
  assign ibus_addr = pc_q;
  assign issue     = ibus_req & ibus_gnt;

  // A response only counts if something is actually outstanding; anything
  // else is a leftover from before a reset and is ignored.
  assign resp_live = ibus_rvalid & (outstanding != '0);
  assign resp_take = resp_live & ~redirect_valid & (discard == '0);

  // A misaligned PC produces an exception entry instead of a bus access, but
  // only after older requests have drained so the entry stays in program order.
  assign misalign_push = ~redirect_valid & ~halt & ~aligned &
                         (outstanding == '0) & (fq_count < CW'(FQ_DEPTH));

  assign fq_push  = resp_take | misalign_push;
  assign fq_pop   = id_valid & id_ready & ~redirect_valid;
  assign set_halt = (resp_take & ibus_err) | misalign_push;

  // Select the entry written into the FQ this cycle.
  always_comb begin
    push_pc    = pc_q;
    push_inst  = '0;
    push_exp   = 1'b1;
    push_cause = 1'b0;
    if (resp_take) begin
      push_pc    = inf_pc[inf_rd];
      push_inst  = ibus_err ? 32'h0 : ibus_rdata;
      push_exp   = ibus_err;
      push_cause = ibus_err;
    end
  end

  // Control state. Redirect wins over everything except reset: it flushes both
  // queues and turns the still-pending responses into a discard count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      halt        <= 1'b0;
      inf_wr      <= '0;
      inf_rd      <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
      fq_count    <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp_live);
      if (redirect_valid) begin
        pc_q     <= redirect_pc;
        halt     <= 1'b0;
        discard  <= outstanding - CW'(resp_live);
        inf_wr   <= '0;
        inf_rd   <= '0;
        fq_wr    <= '0;
        fq_rd    <= '0;
        fq_count <= '0;
      end else begin
        if (issue) begin
          pc_q   <= pc_q + XLEN'(4);
          inf_wr <= ptr_inc(inf_wr);
        end
        if (resp_take) begin
          inf_rd <= ptr_inc(inf_rd);
        end
        if (resp_live && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (set_halt) begin
          halt <= 1'b1;
        end
        if (fq_push) begin
          fq_wr <= ptr_inc(fq_wr);
        end
        if (fq_pop) begin
          fq_rd <= ptr_inc(fq_rd);
        end
        fq_count <= fq_count + CW'(fq_push) - CW'(fq_pop);
      end
    end
  end

  // Queue storage needs no reset: the counters and pointers decide validity.
  always_ff @(posedge clk) begin
    if (issue) begin
      inf_pc[inf_wr] <= pc_q;
    end
    if (fq_push) begin
      fq_pc[fq_wr]    <= push_pc;
      fq_inst[fq_wr]  <= push_inst;
      fq_exp[fq_wr]   <= push_exp;
      fq_cause[fq_wr] <= push_cause;
    end
  end

  // Decode sees only registered FQ state; fields read as zero when empty.
  assign id_valid        = (fq_count != '0);
  assign id_pc           = id_valid ? fq_pc[fq_rd] : '0;
  assign id_inst         = id_valid ? XLEN'(fq_inst[fq_rd]) : '0;
  assign if2id_exp_flag  = id_valid & fq_exp[fq_rd];
  assign if2id_exp_cause = id_valid & fq_cause[fq_rd];

endmodule
